// File: rtl/fx3_rx_pattern_checker_if.sv
// fx3_rx_pattern_checker_if: control, data and result signals between the FX3 test FSM and the pattern checker
interface fx3_rx_pattern_checker_if #(
   parameter int CNT_W = 24,
   parameter int ERR_W = 16
);
   logic             start;
   logic [15:0]      dq_in;
   logic             dq_valid;
   logic             busy;
   logic             done;
   logic             pass;
   logic             timeout;
   logic [CNT_W-1:0] word_cnt;
   logic [ERR_W-1:0] err_cnt;
   logic [CNT_W-1:0] first_err_idx;
   logic [15:0]      first_err_data;
   logic [15:0]      first_err_exp;
   modport master (
      output start, dq_in, dq_valid,
      input  busy, done, pass, timeout, word_cnt, err_cnt, first_err_idx, first_err_data, first_err_exp
   );
   modport slave (
      input  start, dq_in, dq_valid,
      output busy, done, pass, timeout, word_cnt, err_cnt, first_err_idx, first_err_data, first_err_exp
   );
endinterface

// File: rtl/fx3_rx_pattern_checker.sv
// fx3_rx_pattern_checker: checks FX3 rx words against an incrementing pattern, with a stall watchdog.
// Define FX3_CHK_LFSR_EN to check against a 16-bit Fibonacci LFSR sequence instead.
module fx3_rx_pattern_checker #(
   parameter int CNT_W       = 24,
   parameter int ERR_W       = 16,
   parameter int TIMEOUT_CYC = 40000,
   parameter int FRAME_LEN   = 1024
) (
   input logic clk,
   input logic rst,
   fx3_rx_pattern_checker_if.slave bus
);
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {IDLE, SYNC, CHECK, DONE} state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] word_cnt, word_cnt_n, first_err_idx, first_err_idx_n;
   logic [ERR_W-1:0] err_cnt, err_cnt_n, err_inc;
   logic [15:0]      first_err_data, first_err_data_n, first_err_exp, first_err_exp_n;
   logic [15:0]      expected, expected_n, seed;
   logic [WD_W-1:0]  wdog, wdog_n;
   logic             timeout_r, timeout_n, pass_r, pass_n, seed_bad;

   function automatic logic [15:0] pat_next(input logic [15:0] c);
`ifdef FX3_CHK_LFSR_EN
      return {c[14:0], c[15] ^ c[13] ^ c[12] ^ c[10]};
`else
      return c + 16'd1;
`endif
   endfunction

`ifdef FX3_CHK_LFSR_EN
   // an all-zero seed would lock the LFSR, so it is flagged and replaced
   assign seed_bad = bus.dq_in == 16'h0000;
   assign seed     = seed_bad ? 16'h0001 : bus.dq_in;
`else
   assign seed_bad = 1'b0;
   assign seed     = bus.dq_in;
`endif

   assign err_inc = &err_cnt ? err_cnt : err_cnt + ERR_W'(1);

   always_comb begin
      state_n          = state;
      word_cnt_n       = word_cnt;
      err_cnt_n        = err_cnt;
      first_err_idx_n  = first_err_idx;
      first_err_data_n = first_err_data;
      first_err_exp_n  = first_err_exp;
      expected_n       = expected;
      wdog_n           = wdog;
      timeout_n        = timeout_r;
      pass_n           = pass_r;
      case (state)
         IDLE: if (bus.start) begin
            state_n          = SYNC;
            word_cnt_n       = '0;
            err_cnt_n        = '0;
            first_err_idx_n  = '0;
            first_err_data_n = '0;
            first_err_exp_n  = '0;
            wdog_n           = '0;
            timeout_n        = 1'b0;
            pass_n           = 1'b0;
         end
         SYNC, CHECK: if (bus.dq_valid) begin
            wdog_n = '0;
            if (state == SYNC) begin
               expected_n = pat_next(seed);
               word_cnt_n = CNT_W'(1);
               state_n    = (FRAME_LEN == 1) ? DONE : CHECK;
               if (seed_bad) begin
                  err_cnt_n        = ERR_W'(1);
                  first_err_data_n = bus.dq_in;
                  first_err_exp_n  = seed;
               end
            end else begin
               expected_n = pat_next(expected);
               word_cnt_n = word_cnt + CNT_W'(1);
               if (bus.dq_in != expected) begin
                  err_cnt_n = err_inc;
                  if (err_cnt == '0) begin
                     first_err_idx_n  = word_cnt;
                     first_err_data_n = bus.dq_in;
                     first_err_exp_n  = expected;
                  end
               end
               if (word_cnt_n == CNT_W'(FRAME_LEN)) state_n = DONE;
            end
         end else if (wdog == WD_W'(TIMEOUT_CYC - 1)) begin
            state_n   = DONE;
            timeout_n = 1'b1;
         end else begin
            wdog_n = wdog + WD_W'(1);
         end
         default: state_n = IDLE;
      endcase
      if (state != DONE && state_n == DONE) pass_n = (err_cnt_n == '0) && !timeout_n;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         word_cnt       <= '0;
         err_cnt        <= '0;
         first_err_idx  <= '0;
         first_err_data <= '0;
         first_err_exp  <= '0;
         expected       <= '0;
         wdog           <= '0;
         timeout_r      <= 1'b0;
         pass_r         <= 1'b0;
      end else begin
         state          <= state_n;
         word_cnt       <= word_cnt_n;
         err_cnt        <= err_cnt_n;
         first_err_idx  <= first_err_idx_n;
         first_err_data <= first_err_data_n;
         first_err_exp  <= first_err_exp_n;
         expected       <= expected_n;
         wdog           <= wdog_n;
         timeout_r      <= timeout_n;
         pass_r         <= pass_n;
      end
   end

   assign bus.busy           = state == SYNC || state == CHECK;
   assign bus.done           = state == DONE;
   assign bus.pass           = pass_r;
   assign bus.timeout        = timeout_r;
   assign bus.word_cnt       = word_cnt;
   assign bus.err_cnt        = err_cnt;
   assign bus.first_err_idx  = first_err_idx;
   assign bus.first_err_data = first_err_data;
   assign bus.first_err_exp  = first_err_exp;
endmodule

// File: tb/tb_fx3_rx_pattern_checker.sv
// tb_fx3_rx_pattern_checker: directed frame vectors plus watchdog, reset and stray-start sequences.
module tb_fx3_rx_pattern_checker;
   localparam int TO = 500;
   localparam int FL = 1024;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   fx3_rx_pattern_checker_if #(.CNT_W(24), .ERR_W(16)) bus ();

   fx3_rx_pattern_checker #(
      .CNT_W(24), .ERR_W(16), .TIMEOUT_CYC(TO), .FRAME_LEN(FL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   typedef struct {
      logic [15:0] seed;
      int          bad_idx;
      logic [15:0] bad_data;
      bit          gap;
      bit          exp_pass;
      int          exp_err;
      int          exp_idx;
      logic [15:0] exp_data;
      logic [15:0] exp_exp;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic feed(input logic [15:0] seed, input int first, input int n,
                       input int bad_idx, input logic [15:0] bad_data, input bit gap);
      for (int i = first; i < first + n; i++) begin
         bus.dq_valid = 1'b1;
         bus.dq_in    = (i == bad_idx) ? bad_data : seed + 16'(i);
         @(negedge clk);
         if (gap && i < first + n - 1) begin
            bus.dq_valid = 1'b0;
            @(negedge clk);
         end
      end
      bus.dq_valid = 1'b0;
   endtask

   task automatic check_end(input string tag, input bit p, input int w, input int e, input int idx,
                            input logic [15:0] d, input logic [15:0] x, input bit to);
      chk({tag, ".done"}, 32'(bus.done), 32'd1);
      chk({tag, ".pass"}, 32'(bus.pass), 32'(p));
      chk({tag, ".timeout"}, 32'(bus.timeout), 32'(to));
      chk({tag, ".word_cnt"}, 32'(bus.word_cnt), 32'(w));
      chk({tag, ".err_cnt"}, 32'(bus.err_cnt), 32'(e));
      chk({tag, ".first_err_idx"}, 32'(bus.first_err_idx), 32'(idx));
      chk({tag, ".first_err_data"}, 32'(bus.first_err_data), 32'(d));
      chk({tag, ".first_err_exp"}, 32'(bus.first_err_exp), 32'(x));
      @(negedge clk);
      chk({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
      chk({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
      chk({tag, ".done"}, 32'(bus.done), 32'd0);
      chk({tag, ".pass"}, 32'(bus.pass), 32'd0);
      chk({tag, ".timeout"}, 32'(bus.timeout), 32'd0);
      chk({tag, ".word_cnt"}, 32'(bus.word_cnt), 32'd0);
      chk({tag, ".err_cnt"}, 32'(bus.err_cnt), 32'd0);
      chk({tag, ".first_err_idx"}, 32'(bus.first_err_idx), 32'd0);
      chk({tag, ".first_err_data"}, 32'(bus.first_err_data), 32'd0);
      chk({tag, ".first_err_exp"}, 32'(bus.first_err_exp), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int n;
      bus.start    = 1'b0;
      bus.dq_valid = 1'b0;
      bus.dq_in    = 16'h0000;
      vecs[0] = '{16'h0000, -1, 16'h0000, 1'b0, 1'b1, 0, 0, 16'h0000, 16'h0000};
      vecs[1] = '{16'hFFFE, -1, 16'h0000, 1'b0, 1'b1, 0, 0, 16'h0000, 16'h0000};
      vecs[2] = '{16'h0100, 5, 16'hBEEF, 1'b0, 1'b0, 1, 5, 16'hBEEF, 16'h0105};
      vecs[3] = '{16'h1234, 1023, 16'h0000, 1'b0, 1'b0, 1, 1023, 16'h0000, 16'h1633};
      vecs[4] = '{16'h8000, -1, 16'h0000, 1'b1, 1'b1, 0, 0, 16'h0000, 16'h0000};
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 5; v++) begin
         pulse_start();
         chk($sformatf("vec%0d.busy", v), 32'(bus.busy), 32'd1);
         feed(vecs[v].seed, 0, FL, vecs[v].bad_idx, vecs[v].bad_data, vecs[v].gap);
         check_end($sformatf("vec%0d", v), vecs[v].exp_pass, FL, vecs[v].exp_err,
                   vecs[v].exp_idx, vecs[v].exp_data, vecs[v].exp_exp, 1'b0);
      end

      // no words at all: watchdog fires from SYNC
      pulse_start();
      repeat (TO - 1) @(negedge clk);
      chk("sync_wd.busy_before", 32'(bus.busy), 32'd1);
      @(negedge clk);
      check_end("sync_wd", 1'b0, 0, 0, 0, 16'h0000, 16'h0000, 1'b1);

      // a gap one short of the limit survives, then a full stall times out
      pulse_start();
      feed(16'h0050, 0, 1, -1, 16'h0000, 1'b0);
      repeat (TO - 1) @(negedge clk);
      chk("wd_edge.busy", 32'(bus.busy), 32'd1);
      chk("wd_edge.timeout", 32'(bus.timeout), 32'd0);
      feed(16'h0050, 1, 9, -1, 16'h0000, 1'b0);
      n = 0;
      while (!bus.done && n <= TO + 20) begin
         @(negedge clk);
         n++;
      end
      chk("wd.idle_cycles", 32'(n), 32'(TO));
      check_end("wd", 1'b0, 10, 0, 0, 16'h0000, 16'h0000, 1'b1);

      // reset in the middle of CHECK
      pulse_start();
      feed(16'h0000, 0, 300, -1, 16'h0000, 1'b0);
      chk("rst_mid.word_cnt", 32'(bus.word_cnt), 32'd300);
      rst          = 1'b1;
      bus.dq_valid = 1'b1;
      bus.dq_in    = 16'd300;
      @(negedge clk);
      check_zero("rst_mid");
      @(negedge clk);
      chk("rst_mid.no_done", 32'(bus.done), 32'd0);
      rst          = 1'b0;
      bus.dq_valid = 1'b0;
      @(negedge clk);
      pulse_start();
      feed(16'h4000, 0, FL, -1, 16'h0000, 1'b0);
      check_end("after_rst", 1'b1, FL, 0, 0, 16'h0000, 16'h0000, 1'b0);

      // valid words in IDLE leave held results alone
      feed(16'h7777, 0, 5, 1, 16'h1111, 1'b0);
      chk("idle_valid.busy", 32'(bus.busy), 32'd0);
      chk("idle_valid.word_cnt", 32'(bus.word_cnt), 32'(FL));
      chk("idle_valid.err_cnt", 32'(bus.err_cnt), 32'd0);
      chk("idle_valid.pass", 32'(bus.pass), 32'd1);

      // stray start pulses during CHECK and in the DONE cycle
      pulse_start();
      feed(16'h0200, 0, 100, -1, 16'h0000, 1'b0);
      bus.start = 1'b1;
      feed(16'h0200, 100, 1, -1, 16'h0000, 1'b0);
      bus.start = 1'b0;
      feed(16'h0200, 101, 400, -1, 16'h0000, 1'b0);
      bus.start = 1'b1;
      feed(16'h0200, 501, 1, -1, 16'h0000, 1'b0);
      bus.start = 1'b0;
      feed(16'h0200, 502, FL - 502, -1, 16'h0000, 1'b0);
      bus.start = 1'b1;
      check_end("stray_start", 1'b1, FL, 0, 0, 16'h0000, 16'h0000, 1'b0);
      bus.start = 1'b0;
      @(negedge clk);
      chk("start_in_done.busy", 32'(bus.busy), 32'd0);
      chk("start_in_done.word_cnt", 32'(bus.word_cnt), 32'(FL));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fx3_rx_pattern_checker.md
Name: fx3_rx_pattern_checker

Overview:
Consumes the 16-bit word stream that the FX3 test FSM reads from the FX3 chip and checks it against an expected incrementing pattern. It sits directly downstream of the FX3 test FSM data path, on the 40 MHz domain. It reports pass/fail, word and error counts, and a snapshot of the first mismatch so the test FSM can drive its status/interrupt outputs. A watchdog flags a stalled stream.

Parameters:
CNT_W, 24, width of the received-word counter.
ERR_W, 16, width of the error counter (saturating).
TIMEOUT_CYC, 40000, max clk cycles between accepted words while checking (1 ms at 40 MHz).
FRAME_LEN, 1024, words per test frame; checking ends after this many words.

Ports:
clk  in  1  40 MHz clock
rst  in  1  synchronous reset, active-high
start  in  1  single-cycle pulse; arms a new check run
dq_in  in  16  word from the FX3 data bus, registered upstream
dq_valid  in  1  dq_in carries a valid word this cycle
busy  out  1  run in progress (SYNC or CHECK)
done  out  1  single-cycle pulse when a run finishes (frame complete or timeout)
pass  out  1  result of the last run; 1 = FRAME_LEN words, 0 errors, no timeout
timeout  out  1  last run ended by the watchdog
word_cnt  out  CNT_W  words accepted in the current/last run
err_cnt  out  ERR_W  mismatching words, saturates at all-ones
first_err_idx  out  CNT_W  word index of the first mismatch
first_err_data  out  16  received word at the first mismatch
first_err_exp  out  16  expected word at the first mismatch

Behaviour:
- Reset: state IDLE; busy=0, done=0, pass=0, timeout=0, word_cnt=0, err_cnt=0, first_err_*=0. Reset mid-run aborts the run with no done pulse.
- FSM states: IDLE, SYNC, CHECK, DONE.
- IDLE: start=1 -> SYNC. On entry to SYNC, clear word_cnt, err_cnt, first_err_*, timeout, pass and the watchdog. Results of the previous run hold until then.
- SYNC: the first dq_valid word seeds the pattern. expected_next = dq_in + 1 (mod 2^16), word_cnt=1, no error counted -> CHECK. If FRAME_LEN == 1, go directly to DONE with pass=1. The watchdog runs in SYNC too.
- CHECK: each dq_valid word is compared with expected. On mismatch, err_cnt increments (saturating). If this is the first error, capture idx = word_cnt, data = dq_in, exp = expected. After any word, expected = expected + 1. The pattern does not resync on error. word_cnt increments. When the accepted word makes word_cnt == FRAME_LEN -> DONE.
- Pattern wrap: 0xFFFF is followed by 0x0000, and this is not an error.
- Watchdog: counts clk cycles without dq_valid in SYNC/CHECK and reloads on every accepted word. Reaching TIMEOUT_CYC -> DONE with timeout=1, pass=0.
- DONE: one cycle. done=1; pass = (err_cnt==0 && !timeout). Next state is IDLE. busy=0 in IDLE and DONE.
- Latency: err_cnt/word_cnt update 1 cycle after the dq_valid word. done is asserted 1 cycle after the last word.
- start while busy: ignored. start in the DONE cycle: ignored. dq_valid in IDLE/DONE: ignored, counters unchanged.
- Simultaneous last word and watchdog expiry: the word wins; the run completes normally.
- Counter widths: word_cnt does not exceed FRAME_LEN. FRAME_LEN must be below 2^CNT_W.

Optional Feature:
FX3_CHK_LFSR_EN
- Defined: the pattern is a 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1. Next = {cur[14:0], cur[15]^cur[13]^cur[12]^cur[10]}.
- Defined: the SYNC word seeds the LFSR. A seed of 0x0000 is counted as an error in SYNC and replaced by seed 0x0001.
- Not defined: incrementing pattern only, as above.

Test Plan:
- Reset, start, then 1024 valid words 0x0000..0x03FF back-to-back -> done pulse 1 cycle after the last word; pass=1, word_cnt=1024, err_cnt=0.
- Start, then words seeded 0xFFFE, 0xFFFF, 0x0000, 0x0001 ... (1024 words) -> pass=1; the wrap is not flagged.
- Start, 1024-word ramp from 0x0100 with word index 5 forced to 0xBEEF -> err_cnt=1, first_err_idx=5, first_err_data=0xBEEF, first_err_exp=0x0105, pass=0.
- Start, 10 words, then dq_valid held low -> done after exactly TIMEOUT_CYC idle cycles; timeout=1, pass=0, word_cnt=10.
- Assert rst in the middle of CHECK at word 300 -> all outputs 0 the next cycle, no done pulse. A new start then completes a clean run with pass=1.
- start pulses during CHECK plus dq_valid in IDLE -> no restart, counters unaffected; the run finishes with correct counts.
